// File: rtl/pwm_pkg.sv
// Shared types and constants for the three-phase dead-time gate conditioner.
package pwm_pkg;
  localparam int NUM_PH = 3;
  localparam int DT_W   = 8;

  localparam logic [3:0] PWM_DT_ADDR   = 4'h0;
  localparam logic [3:0] PWM_EN_ADDR   = 4'h1;
  localparam logic [3:0] PWM_CLR_ADDR  = 4'h2;
  localparam logic [3:0] PWM_STAT_ADDR = 4'h3;

  typedef enum logic [1:0] {PH_IDLE, PH_HI, PH_LO, PH_DEAD} ph_state_e;

  // Count loaded on entering DEAD; dt=0 still yields one dead cycle.
  function automatic logic [DT_W-1:0] dead_load(input logic [DT_W-1:0] dt);
    return (dt == '0) ? '0 : dt - 1'b1;
  endfunction
endpackage

// File: rtl/pwm_deadtime_if.sv
// Avalon-MM slave bus shared with the modulator register block.
interface pwm_deadtime_if;
  logic [3:0]  MMS_addr;
  logic        MMS_write;
  logic [31:0] MMS_writedata;
  logic        MMS_read;
  logic [31:0] MMS_readdata;

  modport master (output MMS_addr, MMS_write, MMS_writedata, MMS_read, input MMS_readdata);
  modport slave  (input MMS_addr, MMS_write, MMS_writedata, MMS_read, output MMS_readdata);
endinterface

// File: rtl/deadtime_phase.sv
// One half-bridge phase: request decode, dead-time FSM, registered gate outputs.
module deadtime_phase
  import pwm_pkg::*;
(
  input  logic            clk,
  input  logic            reset_n,
  input  logic            u_req,
  input  logic            l_req,
  input  logic            allow,
  input  logic [DT_W-1:0] dt,
  output logic            ugate,
  output logic            lgate,
  output logic            in_dead,
  output logic            shoot
);
  ph_state_e       state;
  logic [DT_W-1:0] cnt;
  logic            want_hi, want_lo;

  assign want_hi = u_req & ~l_req & allow;
  assign want_lo = l_req & ~u_req & allow;
  assign shoot   = u_req & l_req;

  // Gates are flops set alongside the state so they never glitch on decode.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= PH_IDLE;
      cnt     <= '0;
      ugate   <= 1'b0;
      lgate   <= 1'b0;
      in_dead <= 1'b0;
    end else begin
      case (state)
        PH_IDLE: begin
          if (want_hi) begin
            state <= PH_HI; ugate <= 1'b1;
          end else if (want_lo) begin
            state <= PH_LO; lgate <= 1'b1;
          end
        end
        PH_HI: begin
          if (!want_hi) begin
            state <= PH_DEAD; ugate <= 1'b0; in_dead <= 1'b1;
            cnt   <= dead_load(dt);
          end
        end
        PH_LO: begin
          if (!want_lo) begin
            state <= PH_DEAD; lgate <= 1'b0; in_dead <= 1'b1;
            cnt   <= dead_load(dt);
          end
        end
        PH_DEAD: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            in_dead <= 1'b0;
            if (want_hi) begin
              state <= PH_HI; ugate <= 1'b1;
            end else if (want_lo) begin
              state <= PH_LO; lgate <= 1'b1;
            end else begin
              state <= PH_IDLE;
            end
          end
        end
        default: begin
          state <= PH_IDLE; ugate <= 1'b0; lgate <= 1'b0; in_dead <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: rtl/pwm_deadtime.sv
// Register file, fault synchronizer/latch and three dead-time phase channels.
module pwm_deadtime
  import pwm_pkg::*;
#(
  parameter int DT_RESET = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  pwm_deadtime_if.slave     mms,
  input  logic [0:2]        Udrive,
  input  logic [0:2]        Ldrive,
  input  logic              fault_n,
  output logic [0:2]        Ugate,
  output logic [0:2]        Lgate,
  output logic              fault_irq
);
  logic [DT_W-1:0]   dt;
  logic              en;
  logic              fault_lat;
  logic              shoot_err;
  logic [1:0]        fsync;
  logic              fault_s;
  logic              allow;
  logic [NUM_PH-1:0] in_dead;
  logic [NUM_PH-1:0] shoot;
  logic              clr_wr, clr_fault, clr_shoot;
  logic [31:0]       rd_mux;

  assign fault_s   = fsync[1];
  assign allow     = en & ~fault_lat;
  assign clr_wr    = mms.MMS_write && (mms.MMS_addr == PWM_CLR_ADDR);
  assign clr_fault = clr_wr & mms.MMS_writedata[0];
  assign clr_shoot = clr_wr & mms.MMS_writedata[1];

  for (genvar p = 0; p < NUM_PH; p++) begin : g_ph
    deadtime_phase u_ph (
      .clk     (clk),
      .reset_n (reset_n),
      .u_req   (Udrive[p]),
      .l_req   (Ldrive[p]),
      .allow   (allow),
      .dt      (dt),
      .ugate   (Ugate[p]),
      .lgate   (Lgate[p]),
      .in_dead (in_dead[p]),
      .shoot   (shoot[p])
    );
  end

  // fault_n is asynchronous to clk; both stages idle high (no fault).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) fsync <= 2'b11;
    else          fsync <= {fsync[0], fault_n};
  end

  always_comb begin
    rd_mux = '0;
    case (mms.MMS_addr)
      PWM_DT_ADDR:   rd_mux = {{(32-DT_W){1'b0}}, dt};
      PWM_EN_ADDR:   rd_mux = {31'd0, en};
      PWM_STAT_ADDR: rd_mux = {26'd0, in_dead, shoot_err, fault_s, fault_lat};
      default:       rd_mux = '0;
    endcase
  end

  // Set terms are OR'd after the clear so a simultaneous set wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dt               <= DT_RESET[DT_W-1:0];
      en               <= 1'b0;
      fault_lat        <= 1'b0;
      fault_irq        <= 1'b0;
      shoot_err        <= 1'b0;
      mms.MMS_readdata <= '0;
    end else begin
      if (mms.MMS_write && mms.MMS_addr == PWM_DT_ADDR) dt <= mms.MMS_writedata[DT_W-1:0];
      if (mms.MMS_write && mms.MMS_addr == PWM_EN_ADDR) en <= mms.MMS_writedata[0];
      fault_lat        <= ~fault_s | (fault_lat & ~clr_fault);
      fault_irq        <= ~fault_s & ~fault_lat;
      shoot_err        <= (|shoot) | (shoot_err & ~clr_shoot);
      mms.MMS_readdata <= mms.MMS_read ? rd_mux : '0;
    end
  end
endmodule

// File: tb/tb_pwm_deadtime.sv
// Randomized bench for pwm_deadtime against a timestamp-based reference model.
module tb_pwm_deadtime;
  import pwm_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [0:2] Udrive, Ldrive, Ugate, Lgate;
  logic       fault_n, fault_irq;

  pwm_deadtime_if mms();

  pwm_deadtime #(.DT_RESET(16)) dut (
    .clk(clk), .reset_n(reset_n), .mms(mms),
    .Udrive(Udrive), .Ldrive(Ldrive), .fault_n(fault_n),
    .Ugate(Ugate), .Lgate(Lgate), .fault_irq(fault_irq)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;
  int cyc = 0;
  // Model: act = 0 off / 1 upper on / 2 lower on; dead_end = first edge a gate may rise again.
  int act [3];
  int dead_end [3];
  int m_dt;
  bit m_en, m_latch, m_irq, m_shoot;
  bit fq[$];
  bit rd_valid;
  logic [31:0] rd_exp;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int p = 0; p < 3; p++) begin act[p] = 0; dead_end[p] = 0; end
    m_dt = 16; m_en = 0; m_latch = 0; m_irq = 0; m_shoot = 0;
    fq.delete(); fq.push_back(1'b1); fq.push_back(1'b1);
    rd_valid = 0;
  endtask

  task automatic model_edge();
    int  syn, r;
    bit  allow, clr_f, clr_s, any_sh;
    logic [2:0] dead;
    cyc++;
    if (!reset_n) begin model_reset(); return; end
    rd_valid = mms.MMS_read;
    if (mms.MMS_read) begin
      for (int p = 0; p < 3; p++) dead[p] = (act[p] == 0) && (cyc - 1 < dead_end[p]);
      case (mms.MMS_addr)
        PWM_DT_ADDR:   rd_exp = m_dt;
        PWM_EN_ADDR:   rd_exp = {31'd0, m_en};
        PWM_STAT_ADDR: rd_exp = {26'd0, dead, m_shoot, fq[0], m_latch};
        default:       rd_exp = 0;
      endcase
    end
    allow  = m_en && !m_latch;
    any_sh = 0;
    for (int p = 0; p < 3; p++) begin
      r = (Udrive[p] && !Ldrive[p]) ? 1 : (Ldrive[p] && !Udrive[p]) ? 2 : 0;
      if (Udrive[p] && Ldrive[p]) any_sh = 1;
      if (act[p] != 0) begin
        if (r != act[p] || !allow) begin
          act[p] = 0;
          dead_end[p] = cyc + ((m_dt == 0) ? 1 : m_dt);
        end
      end else if (cyc >= dead_end[p] && allow && r != 0) begin
        act[p] = r;
      end
    end
    syn = fq.pop_front();
    fq.push_back(fault_n);
    clr_f = mms.MMS_write && mms.MMS_addr == PWM_CLR_ADDR && mms.MMS_writedata[0];
    clr_s = mms.MMS_write && mms.MMS_addr == PWM_CLR_ADDR && mms.MMS_writedata[1];
    m_irq = (syn == 0) && !m_latch;
    if (syn == 0) m_latch = 1;
    else if (clr_f) m_latch = 0;
    m_shoot = any_sh || (m_shoot && !clr_s);
    if (mms.MMS_write && mms.MMS_addr == PWM_DT_ADDR) m_dt = mms.MMS_writedata[7:0];
    if (mms.MMS_write && mms.MMS_addr == PWM_EN_ADDR) m_en = mms.MMS_writedata[0];
  endtask

  task automatic check_outputs();
    for (int p = 0; p < 3; p++) begin
      chk($sformatf("ugate%0d", p), Ugate[p], act[p] == 1);
      chk($sformatf("lgate%0d", p), Lgate[p], act[p] == 2);
    end
    chk("fault_irq", fault_irq, m_irq);
    if (rd_valid) chk("readdata", mms.MMS_readdata, rd_exp);
    rd_valid = 0;
  endtask

  // Inputs are set just after a negedge; the model samples them at the posedge.
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    mms.MMS_addr = a; mms.MMS_writedata = d; mms.MMS_write = 1'b1;
    tick();
    mms.MMS_write = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a);
    mms.MMS_addr = a; mms.MMS_read = 1'b1;
    tick();
    mms.MMS_read = 1'b0;
  endtask

  task automatic req(input int p, input logic u, input logic l);
    Udrive[p] = u; Ldrive[p] = l;
  endtask

  task automatic rand_cycles(input int n);
    int fcnt = 0;
    int op;
    for (int i = 0; i < n; i++) begin
      for (int p = 0; p < 3; p++)
        if ($urandom_range(0, 7) == 0) begin
          op = $urandom_range(0, 9);
          if (op < 4)      req(p, 1'b1, 1'b0);
          else if (op < 8) req(p, 1'b0, 1'b1);
          else if (op == 8) req(p, 1'b0, 1'b0);
          else             req(p, 1'b1, 1'b1);
        end
      if (fcnt > 0) begin fault_n = 1'b0; fcnt--; end
      else begin
        fault_n = 1'b1;
        if ($urandom_range(0, 79) == 0) fcnt = $urandom_range(1, 4);
      end
      op = $urandom_range(0, 59);
      mms.MMS_write = 1'b0; mms.MMS_read = 1'b0;
      if (op < 10) begin
        mms.MMS_addr = 4'($urandom_range(0, 5)); mms.MMS_read = 1'b1;
      end else if (op < 12) begin
        mms.MMS_addr = PWM_DT_ADDR; mms.MMS_writedata = $urandom_range(0, 7); mms.MMS_write = 1'b1;
      end else if (op < 14) begin
        mms.MMS_addr = PWM_EN_ADDR; mms.MMS_writedata = ($urandom_range(0, 7) != 0) ? 32'd1 : 32'd0;
        mms.MMS_write = 1'b1;
      end else if (op < 18) begin
        mms.MMS_addr = PWM_CLR_ADDR; mms.MMS_writedata = $urandom_range(0, 3); mms.MMS_write = 1'b1;
      end
      tick();
    end
    mms.MMS_write = 1'b0; mms.MMS_read = 1'b0; fault_n = 1'b1;
  endtask

  task automatic async_reset();
    reset_n = 1'b0;
    #1;
    chk("rst_ugate", Ugate, 3'b000);
    chk("rst_lgate", Lgate, 3'b000);
    chk("rst_irq", fault_irq, 1'b0);
    chk("rst_rdata", mms.MMS_readdata, 32'd0);
    model_reset();
    ticks(2);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    Udrive = '0; Ldrive = '0; fault_n = 1'b1;
    mms.MMS_addr = '0; mms.MMS_write = 1'b0; mms.MMS_writedata = '0; mms.MMS_read = 1'b0;
    model_reset();
    @(negedge clk);
    async_reset();
    ticks(2);
    rd(PWM_DT_ADDR); rd(PWM_EN_ADDR); rd(PWM_STAT_ADDR);

    // dt=5 switch-over on phase 0
    wr(PWM_DT_ADDR, 5); wr(PWM_EN_ADDR, 1);
    req(0, 1, 0); ticks(4);
    req(0, 0, 1); ticks(8);
    req(0, 0, 0); ticks(6);

    // dt=0: single dead cycle on phase 1
    wr(PWM_DT_ADDR, 0);
    req(1, 1, 0); ticks(3);
    req(1, 0, 1); ticks(3);
    req(1, 0, 0); ticks(2);

    // shoot-through request on phase 2 while LO
    wr(PWM_DT_ADDR, 3);
    req(2, 0, 1); ticks(3);
    req(2, 1, 1); tick();
    req(2, 0, 1); rd(PWM_STAT_ADDR); ticks(5);
    wr(PWM_CLR_ADDR, 2); rd(PWM_STAT_ADDR);

    // one-cycle fault pulse with all phases switching
    wr(PWM_DT_ADDR, 2);
    for (int k = 0; k < 4; k++) begin
      req(0, k[0], ~k[0]); req(1, ~k[0], k[0]); req(2, k[0], ~k[0]);
      if (k == 2) fault_n = 1'b0;
      tick(); fault_n = 1'b1;
      ticks(3);
    end
    rd(PWM_STAT_ADDR);
    // clear while fault_n still low is ignored, clear afterwards restores gating
    fault_n = 1'b0; ticks(3);
    wr(PWM_CLR_ADDR, 1); rd(PWM_STAT_ADDR);
    fault_n = 1'b1; ticks(3);
    rd(PWM_STAT_ADDR);
    wr(PWM_CLR_ADDR, 1); ticks(4);

    // dt changed mid-DEAD
    Udrive = '0; Ldrive = '0;
    wr(PWM_DT_ADDR, 16); ticks(20);
    req(0, 1, 0); ticks(3);
    req(0, 0, 1); ticks(4);
    wr(PWM_DT_ADDR, 3); ticks(14);
    req(0, 1, 0); ticks(6);
    req(0, 0, 1); ticks(6);

    rand_cycles(3000);

    // reset mid-DEAD with lower gate pending
    wr(PWM_CLR_ADDR, 3); wr(PWM_EN_ADDR, 1); wr(PWM_DT_ADDR, 16);
    Udrive = '0; Ldrive = '0; ticks(20);
    req(0, 1, 0); ticks(3);
    req(0, 0, 1); ticks(5);
    async_reset();
    tick();
    rd(PWM_DT_ADDR); rd(PWM_EN_ADDR);
    for (int i = 0; i < 30; i++) begin
      Udrive = 3'($urandom); Ldrive = 3'($urandom);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
